// File: rtl/mmio_bus_ctrl.sv
// mmio_bus_ctrl: multi-cycle IO window sequencer with slot decode, lane steering, load extension and sticky bus errors.
// Optional access timeout enabled by defining MMIO_TIMEOUT_EN.
module mmio_bus_ctrl #(
  parameter int NDEV = 8,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cpu_rd,
  input  logic            cpu_wr,
  input  logic [31:0]     cpu_addr,
  input  logic [31:0]     cpu_wdata,
  input  logic [2:0]      cpu_funct3,
  output logic            cpu_stall,
  output logic [31:0]     cpu_rdata,
  output logic            dev_valid,
  output logic [NDEV-1:0] dev_sel,
  output logic [3:0]      dev_addr,
  output logic            dev_we,
  output logic [3:0]      dev_be,
  output logic [31:0]     dev_wdata,
  input  logic            dev_ready,
  input  logic [31:0]     dev_rdata,
  output logic            bus_err,
  output logic [31:0]     err_addr
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [1:0] state;
  logic [2:0] f3_q;
  logic [1:0] lo_q;
  logic req, sz_h, sz_w, f3_ok, unmapped, misal, err;
  logic [3:0] be;
  logic [31:0] wd, ld;
  logic [15:0] hw;
  logic [7:0] by;
`ifdef MMIO_TIMEOUT_EN
  logic [7:0] cnt;
  logic [31:0] a_q;
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO_LAST;
`endif
  always_comb begin
    req = cpu_rd | cpu_wr;
    sz_h = cpu_funct3[1:0] == 2'b01;
    sz_w = cpu_funct3[1:0] == 2'b10;
    f3_ok = (cpu_funct3 inside {3'b000, 3'b001, 3'b010}) || (!cpu_wr && (cpu_funct3 inside {3'b100, 3'b101}));
    unmapped = {1'b0, cpu_addr[7:4]} >= 5'(NDEV);
    misal = (sz_h & cpu_addr[0]) | (sz_w & |cpu_addr[1:0]);
    err = (cpu_rd & cpu_wr) | !f3_ok | unmapped | misal;
    be = sz_w ? 4'hf : sz_h ? (cpu_addr[1] ? 4'hc : 4'h3) : 4'b0001 << cpu_addr[1:0];
    wd = sz_w ? cpu_wdata : sz_h ? {2{cpu_wdata[15:0]}} : {4{cpu_wdata[7:0]}};
    by = 8'(dev_rdata >> {lo_q, 3'b000});
    hw = lo_q[1] ? dev_rdata[31:16] : dev_rdata[15:0];
    ld = f3_q[1] ? dev_rdata : f3_q[0] ? {{16{hw[15] & !f3_q[2]}}, hw} : {{24{by[7] & !f3_q[2]}}, by};
  end
  assign cpu_stall = !rst && ((state == S_IDLE && req) || state == S_ACCESS);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      f3_q <= '0;
      lo_q <= '0;
      cpu_rdata <= '0;
      dev_valid <= 1'b0;
      dev_sel <= '0;
      dev_addr <= '0;
      dev_we <= 1'b0;
      dev_be <= '0;
      dev_wdata <= '0;
      bus_err <= 1'b0;
      err_addr <= '0;
`ifdef MMIO_TIMEOUT_EN
      cnt <= '0;
      a_q <= '0;
`endif
    end else if (state == S_IDLE) begin
      if (req && err) begin
        bus_err <= 1'b1;
        if (!bus_err) err_addr <= cpu_addr;
        cpu_rdata <= '0;
        state <= S_RESP;
      end else if (req) begin
        dev_valid <= 1'b1;
        dev_sel <= NDEV'(1) << cpu_addr[7:4];
        dev_addr <= {2'b00, cpu_addr[3:2]};
        dev_we <= cpu_wr;
        dev_be <= be;
        dev_wdata <= wd;
        f3_q <= cpu_funct3;
        lo_q <= cpu_addr[1:0];
        cpu_rdata <= '0;
        state <= S_ACCESS;
`ifdef MMIO_TIMEOUT_EN
        cnt <= '0;
        a_q <= cpu_addr;
`endif
      end
    end else if (state == S_ACCESS) begin
      if (dev_ready) begin
        dev_valid <= 1'b0;
        if (!dev_we) cpu_rdata <= ld;
        state <= S_RESP;
      end
`ifdef MMIO_TIMEOUT_EN
      else if (cnt == TMO_LAST) begin
        dev_valid <= 1'b0;
        bus_err <= 1'b1;
        if (!bus_err) err_addr <= a_q;
        cpu_rdata <= '0;
        state <= S_RESP;
      end else cnt <= cnt + 8'd1;
`endif
    end else begin
      state <= S_IDLE;
    end
  end
endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// tb_mmio_bus_ctrl: directed and randomized checks of mmio_bus_ctrl against a spec-level access model.
module tb_mmio_bus_ctrl;
  localparam int NDEV = 8;
  localparam int TMO = 4;
`ifdef MMIO_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [2:0] cpu_funct3 = '0;
  logic cpu_stall, dev_valid, dev_we, bus_err;
  logic [31:0] cpu_rdata, dev_wdata, err_addr;
  logic [NDEV-1:0] dev_sel;
  logic [3:0] dev_addr, dev_be;
  logic dev_ready = 1'b0;
  logic [31:0] dev_rdata = '0;
  int checks = 0, errors = 0;
  int stalls, acc;
  logic [31:0] o_sel, o_be, o_we, o_addr, o_wd, o_rdata;
  bit m_err = 1'b0;
  logic [31:0] m_err_addr = '0;

  mmio_bus_ctrl #(.NDEV(NDEV), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_funct3(cpu_funct3), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .dev_valid(dev_valid), .dev_sel(dev_sel), .dev_addr(dev_addr), .dev_we(dev_we), .dev_be(dev_be),
    .dev_wdata(dev_wdata), .dev_ready(dev_ready), .dev_rdata(dev_rdata), .bus_err(bus_err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " stall"}, 32'(cpu_stall), 0);
    chk({tag, " valid"}, 32'(dev_valid), 0);
    chk({tag, " sel"}, 32'(dev_sel), 0);
    chk({tag, " we"}, 32'(dev_we), 0);
    chk({tag, " be"}, 32'(dev_be), 0);
    chk({tag, " addr"}, 32'(dev_addr), 0);
    chk({tag, " wdata"}, dev_wdata, 0);
    chk({tag, " rdata"}, cpu_rdata, 0);
    chk({tag, " bus_err"}, 32'(bus_err), 0);
    chk({tag, " err_addr"}, err_addr, 0);
  endtask

  // Drives one IO instruction from IDLE through RESP; ready arrives in ACCESS cycle delay+1.
  task automatic run(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [2:0] f3, input int delay, input logic [31:0] rdval);
    cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata; cpu_funct3 = f3;
    stalls = 0; acc = 0;
    #1;
    while (cpu_stall && stalls < 400) begin
      stalls++;
      if (dev_valid) begin
        acc++;
        o_sel = 32'(dev_sel); o_be = 32'(dev_be); o_we = 32'(dev_we); o_addr = 32'(dev_addr); o_wd = dev_wdata;
        dev_ready = (acc == delay + 1);
        dev_rdata = dev_ready ? rdval : 32'h0;
      end
      @(posedge clk); #1;
      dev_ready = 1'b0; dev_rdata = '0;
    end
    o_rdata = cpu_rdata;
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    @(posedge clk); #1;
  endtask

  // Reference: legality, lanes and extension computed arithmetically from the access rules.
  task automatic xfer(input string tag, input bit rd, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [2:0] f3, input int delay, input logic [31:0] rdval);
    int n, off, slot;
    bit legal, f3_ok, to;
    logic [31:0] mask, val, e_be, e_wd;
    n = 1 << (f3 & 3);
    slot = (addr >> 4) & 15;
    f3_ok = wr ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
    legal = !(rd && wr) && f3_ok && slot < NDEV && (addr % n) == 0;
    to = TMO_EN && legal && delay + 1 > TMO;
    off = addr % 4;
    mask = (n == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * n)) - 1;
    val = (rdval >> (8 * off)) & mask;
    if (f3 < 4 && n < 4 && val[8 * n - 1]) val = val | ~mask;
    e_be = ((32'h1 << n) - 1) << off;
    e_wd = (n == 4) ? wdata : (n == 2) ? (wdata & 32'hFFFF) * 32'h0001_0001 : (wdata & 32'hFF) * 32'h0101_0101;
    if (!legal || to) begin
      if (!m_err) m_err_addr = addr;
      m_err = 1'b1;
    end
    run(rd, wr, addr, wdata, f3, delay, rdval);
    chk({tag, " stalls"}, stalls, !legal ? 1 : to ? 1 + TMO : 2 + delay);
    chk({tag, " access_cycles"}, acc, !legal ? 0 : to ? TMO : delay + 1);
    if (legal) begin
      chk({tag, " sel"}, o_sel, 32'h1 << slot);
      chk({tag, " be"}, o_be, e_be);
      chk({tag, " we"}, o_we, 32'(wr));
      chk({tag, " dev_addr"}, o_addr, (addr >> 2) & 3);
      if (wr) chk({tag, " wdata"}, o_wd, e_wd);
    end
    if (!legal || to) chk({tag, " rdata_err"}, o_rdata, 0);
    else if (rd) chk({tag, " rdata"}, o_rdata, val);
    chk({tag, " bus_err"}, 32'(bus_err), 32'(m_err));
    chk({tag, " err_addr"}, err_addr, m_err_addr);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    chk_idle_outputs("post_reset");
    xfer("lw_slot1", 1, 0, 32'hFFFF_FC10, 0, 3'b010, 0, 32'h8000_00F0);
    chk("lw_slot1 sel_const", o_sel, 32'h02);
    chk("lw_slot1 rdata_const", o_rdata, 32'h8000_00F0);
    xfer("lb", 1, 0, 32'hFFFF_FC23, 0, 3'b000, 1, 32'h80AA_BBCC);
    chk("lb const", o_rdata, 32'hFFFF_FF80);
    xfer("lbu", 1, 0, 32'hFFFF_FC23, 0, 3'b100, 0, 32'h80AA_BBCC);
    chk("lbu const", o_rdata, 32'h0000_0080);
    xfer("sh", 0, 1, 32'hFFFF_FC32, 32'h1234_ABCD, 3'b001, 2, 0);
    chk("sh wdata_const", o_wd, 32'hABCD_ABCD);
    chk("sh be_const", o_be, 32'hC);
    xfer("lw_unmapped", 1, 0, 32'hFFFF_FC90, 0, 3'b010, 0, 32'hDEAD_BEEF);
    xfer("sw_misaligned", 0, 1, 32'hFFFF_FC02, 32'h5555_AAAA, 3'b010, 0, 0);
    chk("first_err_addr const", err_addr, 32'hFFFF_FC90);
    xfer("ready_cycle4", 1, 0, 32'hFFFF_FC44, 0, 3'b101, TMO - 1, 32'hF00D_9ABC);
    xfer("rd_wr_both", 1, 1, 32'hFFFF_FC00, 0, 3'b010, 0, 0);
    xfer("store_f3_100", 0, 1, 32'hFFFF_FC01, 0, 3'b100, 0, 0);
`ifdef MMIO_TIMEOUT_EN
    xfer("timeout", 1, 0, 32'hFFFF_FC50, 0, 3'b010, 20, 32'h1111_2222);
`endif
    for (int i = 0; i < 200; i++) begin
      logic [2:0] f3;
      logic [31:0] a;
      bit rd, wr;
      int k;
      k = $urandom_range(0, 19);
      rd = (k < 10) || (k == 19);
      wr = !rd || (k == 19);
      f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : (rd ? 3'($urandom_range(0, 5)) : 3'($urandom_range(0, 2)));
      a = {24'hFFFFFC, 4'($urandom_range(0, 9)), 4'($urandom)};
      xfer($sformatf("rand%0d", i), rd, wr, a, $urandom, f3, $urandom_range(0, TMO_EN ? 5 : 3), $urandom);
    end
    cpu_rd = 1'b1; cpu_addr = 32'hFFFF_FC24; cpu_funct3 = 3'b010;
    @(posedge clk); #1;
    chk("rst_mid first_access valid", 32'(dev_valid), 1);
    @(posedge clk); #1;
    chk("rst_mid second_access valid", 32'(dev_valid), 1);
    rst = 1'b1;
    #1;
    chk("rst_mid stall_forced", 32'(cpu_stall), 0);
    @(posedge clk); #1;
    cpu_rd = 1'b0;
    chk_idle_outputs("rst_mid");
    rst = 1'b0; m_err = 1'b0; m_err_addr = '0;
    dev_ready = 1'b1;
    @(posedge clk); #1;
    chk("after_rst valid", 32'(dev_valid), 0);
    dev_ready = 1'b0;
    xfer("after_rst lhu", 1, 0, 32'hFFFF_FC06, 0, 3'b101, 0, 32'h9876_5432);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
